shot_resolver: RTL and testbench
================================

Name: shot_resolver

Overview:
- Parametrised successor of the single-target cursor/hit logic.
- Registers the gun cursor position once per frame and draws it as a disc of configurable radius.
- Debounces the trigger to one shot per press and tracks remaining ammunition.
- Resolves each shot against N_TARGETS duck boxes with a sequential scan FSM, then pulses per-target hit flags to the game controller.

Parameters:
- N_TARGETS, 2, number of duck sprites checked per shot (1..8).
- HALF_SIZE, 32, sprite half-width in px; target centre = corner + HALF_SIZE.
- HIT_RADIUS, 32, max |dx| and |dy| (inclusive) from target centre that counts as a hit.
- CURSOR_SIZE, 6, cursor disc radius in px.
- SHOTS_PER_ROUND, 3, ammunition loaded on reset/reload.
- PLAY_STATE, 3'b010, game state code in which shots are resolved.
- X_MAX, 639 / Y_MAX, 479, screen bounds for cursor clamping.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  ~60 Hz frame strobe (level, sampled on Clk).
- shot  in  1  raw trigger level.
- reload  in  1  one-cycle pulse; refills ammunition.
- state  in  3  game controller state.
- x, y  in  10 each  raw cursor coordinates.
- duck_xy  in  20*N_TARGETS  packed {y[9:0],x[9:0]} top-left corner per target; target i at bits [20i+19:20i].
- duck_alive  in  N_TARGETS  target i is eligible for hits.
- DrawX, DrawY  in  10 each  current VGA pixel.
- hit_vec  out  N_TARGETS  one-cycle pulse; bit i = target i hit.
- miss  out  1  one-cycle pulse; resolved shot hit nothing.
- shots_left  out  $clog2(SHOTS_PER_ROUND+1)  remaining ammunition.
- no_shots_left  out  1  shots_left == 0.
- busy  out  1  FSM not in IDLE.
- is_cursor  out  1  combinational; current pixel belongs to cursor.

Behaviour:
Reset (Reset_n low, async):
- cursor = (320,240); shots_left = SHOTS_PER_ROUND; FSM = IDLE.
- hit_vec = 0, miss = 0, busy = 0, pending = 0, edge registers = 0.
- Asserting Reset_n mid-scan aborts the scan; no pulse is emitted.

Edge detection:
- shot_edge = shot & ~shot_q (shot_q registered).
- frame_rise = registered (frame_clk & ~frame_q); one Clk of latency.

Cursor register:
- On frame_rise, load cursor = x, y clamped to X_MAX, Y_MAX.
- The value is held between frames.

Ammunition:
- shot_edge with state==PLAY_STATE, shots_left>0, and FSM in IDLE decrements shots_left and sets pending.
- Any other shot_edge is ignored and does not decrement.
- reload sets shots_left = SHOTS_PER_ROUND and clears pending.
- reload wins over a shot_edge in the same cycle; that shot is discarded.
- The counter saturates at 0 and never wraps.

FSM:
- IDLE -> SNAP: on frame_rise with pending.
- SNAP: latch cursor and duck_xy/duck_alive into shadow registers; clear pending; idx = 0; acc = 0; -> SCAN.
- SCAN: one target per cycle. acc[idx] = alive & |cx_t - cur_x| <= HIT_RADIUS & |cy_t - cur_y| <= HIT_RADIUS.
  - Differences use 12-bit signed arithmetic, so no underflow near screen edges.
  - After idx == N_TARGETS-1 -> REPORT.
- REPORT: hit_vec = acc for exactly one cycle; miss = (acc == 0); -> IDLE.
- Latency: frame_rise to REPORT = N_TARGETS + 2 cycles.
- If state leaves PLAY_STATE while pending, pending is cleared and ammunition is not refunded.
- Changes to duck inputs during SCAN do not affect the result (shadow copy).

Cursor draw:
- is_cursor = dx*dx + dy*dy <= CURSOR_SIZE^2, with dx/dy signed 11-bit differences from the cursor.

Optional Feature:
- Macro: SHOT_RESOLVER_CROSSHAIR_EN.
- Defined: is_cursor is true for the disc ring CURSOR_SIZE-1 <= r^2 bounds (outline only), plus horizontal and vertical crosshair lines of length 2*CURSOR_SIZE+1 centred on the cursor, 1 px thick.
- Undefined: filled disc as above. FSM and hit logic are unaffected in both cases.

Test Plan:
- Reset, N_TARGETS=2, ducks at (100,100) and (400,300) alive, cursor (132,132), shot press, frame_rise -> hit_vec=2'b01 pulse at frame_rise+4 cycles; shots_left 3->2; miss=0.
- Hold shot high across 5 frames -> exactly one decrement and one REPORT; release and re-press -> second shot resolved.
- Cursor (165,132) vs duck (100,100) -> miss pulse (dx=33). Cursor (164,132) -> hit (dx=32, inclusive).
- Fire 3 shots, then a 4th -> no_shots_left=1, 4th ignored (no busy, no pulse); reload coincident with shot edge -> shots_left=3, no pending.
- Both ducks overlapping the cursor, duck 1 alive=0 -> hit_vec=2'b01. Change duck_xy during SCAN -> result unchanged.
- Drop Reset_n during SCAN -> outputs 0 immediately, shots_left=3, no REPORT after release.

Source files
------------

// File: rtl/shot_resolver.sv
// Gun cursor register/draw, trigger debounce with ammunition, and a sequential
// hit-scan FSM over N_TARGETS duck boxes. Define SHOT_RESOLVER_CROSSHAIR_EN for an outlined crosshair cursor.
module shot_resolver #(
  parameter int          N_TARGETS       = 2,
  parameter int          HALF_SIZE       = 32,
  parameter int          HIT_RADIUS      = 32,
  parameter int          CURSOR_SIZE     = 6,
  parameter int          SHOTS_PER_ROUND = 3,
  parameter logic [2:0]  PLAY_STATE      = 3'b010,
  parameter int          X_MAX           = 639,
  parameter int          Y_MAX           = 479
) (
  input  logic                                   Clk,
  input  logic                                   Reset_n,
  input  logic                                   frame_clk,
  input  logic                                   shot,
  input  logic                                   reload,
  input  logic [2:0]                             state,
  input  logic [9:0]                             x,
  input  logic [9:0]                             y,
  input  logic [20*N_TARGETS-1:0]                duck_xy,
  input  logic [N_TARGETS-1:0]                   duck_alive,
  input  logic [9:0]                             DrawX,
  input  logic [9:0]                             DrawY,
  output logic [N_TARGETS-1:0]                   hit_vec,
  output logic                                   miss,
  output logic [$clog2(SHOTS_PER_ROUND+1)-1:0]   shots_left,
  output logic                                   no_shots_left,
  output logic                                   busy,
  output logic                                   is_cursor
);

  localparam int SL_W  = $clog2(SHOTS_PER_ROUND + 1);
  localparam int IDX_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

  localparam logic [SL_W-1:0]    SHOTS_FULL = SL_W'(SHOTS_PER_ROUND);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_TARGETS - 1);
  localparam logic [9:0]         X_LIM      = 10'(X_MAX);
  localparam logic [9:0]         Y_LIM      = 10'(Y_MAX);
  localparam logic signed [11:0] HALF_12    = 12'(HALF_SIZE);
  localparam logic signed [11:0] HIT_12     = 12'(HIT_RADIUS);
  localparam logic signed [22:0] R_OUT      = 23'(CURSOR_SIZE * CURSOR_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_SCAN,
    S_REPORT
  } fsm_e;

  fsm_e                   fsm_q, fsm_d;
  logic                   shot_q;
  logic                   frame_q;
  logic                   frame_rise_q, frame_rise_d;
  logic [9:0]             cur_x_q, cur_x_d;
  logic [9:0]             cur_y_q, cur_y_d;
  logic [SL_W-1:0]        shots_q, shots_d;
  logic                   pending_q, pending_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_TARGETS-1:0]   acc_q, acc_d;
  logic [9:0]             snap_x_q, snap_x_d;
  logic [9:0]             snap_y_q, snap_y_d;
  logic [20*N_TARGETS-1:0] snap_duck_q, snap_duck_d;
  logic [N_TARGETS-1:0]   snap_alive_q, snap_alive_d;

  logic                   shot_edge;
  logic                   in_play;
  logic                   fire_ok;
  logic [19:0]            sel_duck;
  logic signed [11:0]     tdx, tdy, adx, ady;
  logic                   target_hit;

  // Edge detection, cursor capture and ammunition bookkeeping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    shot_edge    = shot & ~shot_q;
    frame_rise_d = frame_clk & ~frame_q;
    in_play      = (state == PLAY_STATE);
    fire_ok      = shot_edge & in_play & (shots_q != '0) & (fsm_q == S_IDLE);

    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (frame_rise_q) begin
      cur_x_d = (x > X_LIM) ? X_LIM : x;
      cur_y_d = (y > Y_LIM) ? Y_LIM : y;
    end

    shots_d   = shots_q;
    pending_d = pending_q;
    if (reload) begin
      // Reload discards any coincident trigger edge.
      shots_d   = SHOTS_FULL;
      pending_d = 1'b0;
    end else begin
      if (fire_ok) begin
        shots_d   = shots_q - SL_W'(1);
        pending_d = 1'b1;
      end
      if (!in_play || fsm_q == S_SNAP) pending_d = 1'b0;
    end
  end

  // Box test for the target currently addressed by the scan index.
  always_comb begin
    sel_duck   = snap_duck_q[20*idx_q +: 20];
    tdx        = $signed({2'b00, sel_duck[9:0]})  + HALF_12 - $signed({2'b00, snap_x_q});
    tdy        = $signed({2'b00, sel_duck[19:10]}) + HALF_12 - $signed({2'b00, snap_y_q});
    adx        = tdx[11] ? -tdx : tdx;
    ady        = tdy[11] ? -tdy : tdy;
    target_hit = snap_alive_q[idx_q] && (adx <= HIT_12) && (ady <= HIT_12);
  end

  always_comb begin
    fsm_d        = fsm_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    snap_duck_d  = snap_duck_q;
    snap_alive_d = snap_alive_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (frame_rise_q && pending_q && in_play) fsm_d = S_SNAP;
      end
      S_SNAP: begin
        snap_x_d     = cur_x_q;
        snap_y_d     = cur_y_q;
        snap_duck_d  = duck_xy;
        snap_alive_d = duck_alive;
        idx_d        = '0;
        acc_d        = '0;
        fsm_d        = S_SCAN;
      end
      S_SCAN: begin
        acc_d[idx_q] = target_hit;
        if (idx_q == IDX_LAST) fsm_d = S_REPORT;
        else                   idx_d = idx_q + IDX_W'(1);
      end
      S_REPORT: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm_q        <= S_IDLE;
      shot_q       <= 1'b0;
      frame_q      <= 1'b0;
      frame_rise_q <= 1'b0;
      cur_x_q      <= 10'd320;
      cur_y_q      <= 10'd240;
      shots_q      <= SHOTS_FULL;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      acc_q        <= '0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      snap_duck_q  <= '0;
      snap_alive_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      fsm_q        <= fsm_d;
      shot_q       <= shot;
      frame_q      <= frame_clk;
      frame_rise_q <= frame_rise_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      shots_q      <= shots_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
      snap_duck_q  <= snap_duck_d;
      snap_alive_q <= snap_alive_d;
    end
  end

  assign hit_vec       = (fsm_q == S_REPORT) ? acc_q : '0;
  assign miss          = (fsm_q == S_REPORT) && (acc_q == '0);
  assign busy          = (fsm_q != S_IDLE);
  assign shots_left    = shots_q;
  assign no_shots_left = (shots_q == '0);

  logic signed [10:0] ddx, ddy;
  logic signed [22:0] ddx_w, ddy_w, r2;

  always_comb begin
    ddx   = $signed({1'b0, DrawX}) - $signed({1'b0, cur_x_q});
    ddy   = $signed({1'b0, DrawY}) - $signed({1'b0, cur_y_q});
    ddx_w = 23'(ddx);
    ddy_w = 23'(ddy);
    r2    = ddx_w * ddx_w + ddy_w * ddy_w;
  end

`ifdef SHOT_RESOLVER_CROSSHAIR_EN
  localparam logic signed [22:0] R_IN  = 23'((CURSOR_SIZE - 1) * (CURSOR_SIZE - 1));
  localparam logic signed [10:0] CS_11 = 11'(CURSOR_SIZE);
  logic on_ring, on_h, on_v;
  always_comb begin
    on_ring   = (r2 >= R_IN) && (r2 <= R_OUT);
    on_h      = (ddy == 11'sd0) && (ddx >= -CS_11) && (ddx <= CS_11);
    on_v      = (ddx == 11'sd0) && (ddy >= -CS_11) && (ddy <= CS_11);
    is_cursor = on_ring | on_h | on_v;
  end
`else
  assign is_cursor = (r2 <= R_OUT);
`endif

endmodule

// File: tb/tb_shot_resolver.sv
// Directed, table-driven bench for shot_resolver with default parameters
// (two targets, three shots, 6 px cursor).
module tb_shot_resolver;

  localparam logic [2:0] PLAY = 3'b010;

  logic       clk;
  logic       rst_n;
  logic       frame_clk;
  logic       shot;
  logic       reload;
  logic [2:0] game_state;
  logic [9:0] x, y;
  logic [39:0] duck_xy;
  logic [1:0] duck_alive;
  logic [9:0] draw_x, draw_y;
  logic [1:0] hit_vec;
  logic       miss;
  logic [1:0] shots_left;
  logic       no_shots_left;
  logic       busy;
  logic       is_cursor;

  shot_resolver dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .frame_clk     (frame_clk),
    .shot          (shot),
    .reload        (reload),
    .state         (game_state),
    .x             (x),
    .y             (y),
    .duck_xy       (duck_xy),
    .duck_alive    (duck_alive),
    .DrawX         (draw_x),
    .DrawY         (draw_y),
    .hit_vec       (hit_vec),
    .miss          (miss),
    .shots_left    (shots_left),
    .no_shots_left (no_shots_left),
    .busy          (busy),
    .is_cursor     (is_cursor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reload_pulse();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic fire();
    shot = 1'b1;
    tick();
    shot = 1'b0;
    tick();
  endtask

  // Raise frame_clk and wait (bounded) for a report pulse; lat counts
  // clocks from the rising frame_clk, 0 means no pulse arrived.
  task automatic frame_wait(output logic [1:0] hv, output logic m, output int lat);
    hv  = '0;
    m   = 1'b0;
    lat = 0;
    frame_clk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (hit_vec != 2'b00 || miss) begin
        hv  = hit_vec;
        m   = miss;
        lat = i;
        break;
      end
    end
    frame_clk = 1'b0;
    tick();
  endtask

  task automatic run_count(input int n, inout int pulses, inout int busy_seen);
    for (int i = 0; i < n; i++) begin
      tick();
      if (hit_vec != 2'b00 || miss) pulses++;
      if (busy) busy_seen++;
    end
  endtask

  task automatic frame_idle(inout int pulses, inout int busy_seen);
    frame_clk = 1'b1;
    run_count(6, pulses, busy_seen);
    frame_clk = 1'b0;
    run_count(3, pulses, busy_seen);
  endtask

  typedef struct {
    logic [9:0] cx, cy, d0x, d0y, d1x, d1y;
    logic [1:0] alive;
    logic [1:0] exp_hv;
    logic       exp_miss;
  } vec_t;

  typedef struct {
    logic [9:0] dx, dy;
    logic       exp;
  } draw_t;

  vec_t  vecs  [12];
  draw_t draws [8];

  logic [1:0] hv;
  logic       m;
  int         lat;
  int         pulses;
  int         busy_seen;

  initial begin
    vecs[0]  = '{10'd132,  10'd132,  10'd100, 10'd100, 10'd400, 10'd300, 2'b11, 2'b01, 1'b0};
    vecs[1]  = '{10'd165,  10'd132,  10'd100, 10'd100, 10'd400, 10'd300, 2'b11, 2'b00, 1'b1};
    vecs[2]  = '{10'd164,  10'd132,  10'd100, 10'd100, 10'd400, 10'd300, 2'b11, 2'b01, 1'b0};
    vecs[3]  = '{10'd132,  10'd165,  10'd100, 10'd100, 10'd400, 10'd300, 2'b11, 2'b00, 1'b1};
    vecs[4]  = '{10'd432,  10'd332,  10'd100, 10'd100, 10'd400, 10'd300, 2'b11, 2'b10, 1'b0};
    vecs[5]  = '{10'd100,  10'd100,  10'd100, 10'd100, 10'd400, 10'd300, 2'b11, 2'b01, 1'b0};
    vecs[6]  = '{10'd99,   10'd100,  10'd100, 10'd100, 10'd400, 10'd300, 2'b11, 2'b00, 1'b1};
    vecs[7]  = '{10'd132,  10'd132,  10'd100, 10'd100, 10'd100, 10'd100, 2'b01, 2'b01, 1'b0};
    vecs[8]  = '{10'd132,  10'd132,  10'd100, 10'd100, 10'd100, 10'd100, 2'b11, 2'b11, 1'b0};
    vecs[9]  = '{10'd132,  10'd132,  10'd100, 10'd100, 10'd100, 10'd100, 2'b00, 2'b00, 1'b1};
    vecs[10] = '{10'd1000, 10'd1000, 10'd600, 10'd440, 10'd0,   10'd0,   2'b11, 2'b01, 1'b0};
    vecs[11] = '{10'd0,    10'd0,    10'd600, 10'd440, 10'd0,   10'd0,   2'b11, 2'b10, 1'b0};

    // Cursor parked at (132,132).
    draws[0] = '{10'd132, 10'd132, 1'b1};
    draws[1] = '{10'd138, 10'd132, 1'b1};
    draws[2] = '{10'd139, 10'd132, 1'b0};
    draws[3] = '{10'd136, 10'd136, 1'b1};
    draws[4] = '{10'd137, 10'd136, 1'b0};
    draws[5] = '{10'd126, 10'd132, 1'b1};
    draws[6] = '{10'd132, 10'd125, 1'b0};
`ifdef SHOT_RESOLVER_CROSSHAIR_EN
    draws[7] = '{10'd133, 10'd133, 1'b0};
`else
    draws[7] = '{10'd133, 10'd133, 1'b1};
`endif

    rst_n      = 1'b0;
    frame_clk  = 1'b0;
    shot       = 1'b0;
    reload     = 1'b0;
    game_state = PLAY;
    x          = '0;
    y          = '0;
    duck_xy    = '0;
    duck_alive = '0;
    draw_x     = 10'd320;
    draw_y     = 10'd240;
    repeat (3) tick();

    check("rst_shots",   32'(shots_left), 32'd3);
    check("rst_noshots", 32'(no_shots_left), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_hit",     32'(hit_vec), 32'd0);
    check("rst_miss",    32'(miss), 32'd0);
    check("rst_cursor",  32'(is_cursor), 32'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      reload_pulse();
      x          = vecs[i].cx;
      y          = vecs[i].cy;
      duck_xy    = {vecs[i].d1y, vecs[i].d1x, vecs[i].d0y, vecs[i].d0x};
      duck_alive = vecs[i].alive;
      fire();
      check($sformatf("v%0d_shots", i), 32'(shots_left), 32'd2);
      frame_wait(hv, m, lat);
      check($sformatf("v%0d_hit", i),     32'(hv), 32'(vecs[i].exp_hv));
      check($sformatf("v%0d_miss", i),    32'(m), 32'(vecs[i].exp_miss));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("v%0d_clear", i),   32'({hit_vec, miss}), 32'd0);
      check($sformatf("v%0d_idle", i),    32'(busy), 32'd0);
    end

    // Cursor drawing around a parked cursor (no shot pending).
    x = 10'd132;
    y = 10'd132;
    pulses = 0; busy_seen = 0;
    frame_idle(pulses, busy_seen);
    check("draw_no_report", 32'(pulses + busy_seen), 32'd0);
    for (int i = 0; i < 8; i++) begin
      draw_x = draws[i].dx;
      draw_y = draws[i].dy;
      #1;
      check($sformatf("draw%0d", i), 32'(is_cursor), 32'(draws[i].exp));
    end

    // Trigger held across five frames resolves exactly one shot.
    reload_pulse();
    x = 10'd132; y = 10'd132;
    duck_xy = {10'd300, 10'd400, 10'd100, 10'd100};
    duck_alive = 2'b11;
    shot = 1'b1;
    pulses = 0; busy_seen = 0;
    for (int f = 0; f < 5; f++) begin
      frame_clk = 1'b1;
      run_count(4, pulses, busy_seen);
      frame_clk = 1'b0;
      run_count(4, pulses, busy_seen);
    end
    check("hold_reports", 32'(pulses), 32'd1);
    check("hold_shots",   32'(shots_left), 32'd2);
    shot = 1'b0;
    tick();
    fire();
    frame_wait(hv, m, lat);
    check("repress_hit",   32'(hv), 32'd1);
    check("repress_shots", 32'(shots_left), 32'd1);

    // Exhaust ammunition, then a fourth trigger is ignored.
    reload_pulse();
    for (int s = 0; s < 3; s++) begin
      fire();
      frame_wait(hv, m, lat);
      check($sformatf("ammo%0d_resolved", s), 32'(lat != 0), 32'd1);
    end
    check("empty_shots",   32'(shots_left), 32'd0);
    check("empty_flag",    32'(no_shots_left), 32'd1);
    fire();
    check("empty_no_wrap", 32'(shots_left), 32'd0);
    pulses = 0; busy_seen = 0;
    frame_idle(pulses, busy_seen);
    check("empty_pulses", 32'(pulses), 32'd0);
    check("empty_busy",   32'(busy_seen), 32'd0);

    // Reload coincident with a trigger edge drops that shot.
    reload = 1'b1;
    shot   = 1'b1;
    tick();
    reload = 1'b0;
    shot   = 1'b0;
    tick();
    check("reload_shots", 32'(shots_left), 32'd3);
    pulses = 0; busy_seen = 0;
    frame_idle(pulses, busy_seen);
    check("reload_no_pending", 32'(pulses + busy_seen), 32'd0);

    // Leaving play while pending cancels the shot without a refund.
    fire();
    check("leave_shots_dec", 32'(shots_left), 32'd2);
    game_state = 3'b000;
    tick();
    game_state = PLAY;
    pulses = 0; busy_seen = 0;
    frame_idle(pulses, busy_seen);
    check("leave_no_report", 32'(pulses + busy_seen), 32'd0);
    check("leave_no_refund", 32'(shots_left), 32'd2);
    game_state = 3'b001;
    fire();
    check("notplay_ignored", 32'(shots_left), 32'd2);
    game_state = PLAY;

    // Duck inputs changed mid-scan do not alter the result.
    reload_pulse();
    x = 10'd132; y = 10'd132;
    duck_xy = {10'd300, 10'd400, 10'd100, 10'd100};
    duck_alive = 2'b11;
    fire();
    frame_clk = 1'b1;
    repeat (3) tick();
    check("scan_busy", 32'(busy), 32'd1);
    duck_xy    = {10'd100, 10'd100, 10'd400, 10'd400};
    duck_alive = 2'b10;
    hv = '0; m = 1'b0; lat = 0;
    for (int i = 4; i <= 12; i++) begin
      tick();
      if (hit_vec != 2'b00 || miss) begin
        hv = hit_vec; m = miss; lat = i;
        break;
      end
    end
    frame_clk = 1'b0;
    tick();
    check("shadow_hit",     32'(hv), 32'd1);
    check("shadow_miss",    32'(m), 32'd0);
    check("shadow_latency", 32'(lat), 32'd5);

    // Asynchronous reset during a scan aborts it.
    reload_pulse();
    fire();
    check("abort_armed", 32'(shots_left), 32'd2);
    frame_clk = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_hit",   32'(hit_vec), 32'd0);
    check("abort_miss",  32'(miss), 32'd0);
    check("abort_shots", 32'(shots_left), 32'd3);
    frame_clk = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    pulses = 0; busy_seen = 0;
    run_count(4, pulses, busy_seen);
    frame_idle(pulses, busy_seen);
    check("abort_no_report", 32'(pulses + busy_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
